// File: rtl/window_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// window_scheduler_pkg
//
// Shared definitions for the sliding-window scheduler:
//   - default grid geometry (image size, window side, stride, address width)
//   - classifier handshake timeout default
//   - helper functions deriving the row stride and last window origin
//   - FSM state encoding
//   - saturating counter helper
// -----------------------------------------------------------------------------
package window_scheduler_pkg;

  // Default geometry of the integral image and the window grid.
  localparam int IMG_W_DEF   = 160;
  localparam int IMG_H_DEF   = 120;
  localparam int WIN_DEF     = 24;
  localparam int STEP_DEF    = 4;
  localparam int ADDR_W_DEF  = 15;
  localparam int TIMEOUT_DEF = 4095;

  // Buffer address distance between two consecutive window rows.
  // Only ever evaluated on constants, so no multiplier is built.
  function automatic int calc_row_stride(input int step, input int img_w);
    return step * img_w;
  endfunction

  // Last legal window origin along one axis.
  function automatic int calc_last_pos(input int extent, input int win);
    return extent - win;
  endfunction

  // FSM encoding, kept as plain constants so older tools and waveform
  // viewers see stable numeric values.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ISSUE   = 3'd1;
  localparam state_t S_WAIT    = 3'd2;
  localparam state_t S_ADVANCE = 3'd3;
  localparam state_t S_DONE    = 3'd4;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/window_timeout_counter.sv
// -----------------------------------------------------------------------------
// window_timeout_counter
//
// Down-counter guarding a start/done handshake. Loaded with LOAD_VAL, it
// counts down while i_dec is high and parks at zero. o_expired is high
// whenever the count is zero; the owner qualifies it with its own wait state.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (count -> 0)
//   i_load     in   load LOAD_VAL (has priority over i_dec)
//   i_dec      in   decrement by one, saturating at zero
//   o_expired  out  count is zero
// -----------------------------------------------------------------------------
module window_timeout_counter #(
  parameter int WIDTH    = 12,
  parameter int LOAD_VAL = 4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] LOAD_CNT = WIDTH'(LOAD_VAL);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_CNT;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_ONE;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/window_scheduler.sv
// -----------------------------------------------------------------------------
// window_scheduler
//
// Walks the cascade classifier over every sliding-window position of the
// integral image, one window per start/done handshake, in raster order with
// x fastest. Counts positive windows (saturating), remembers the first hit,
// flags windows whose classifier answer never came, and flags frames that
// arrived while a scan was still running.
//
// Ports:
//   clk              in   pixel clock, single domain
//   rst_n            in   asynchronous active-low reset
//   frame_ready      in   pulse: integral image ready, start a scan
//   win_start        out  pulse: evaluate window at win_origin
//   win_origin       out  top-left buffer address, y*IMG_W + x
//   win_x / win_y    out  window origin coordinates
//   win_done         in   pulse: classifier finished current window
//   win_hit          in   classifier verdict, qualified by win_done
//   scan_busy        out  scan in progress (through the DONE cycle)
//   scan_done        out  pulse: scan finished
//   hit_count        out  positive windows this scan, saturating at 255
//   first_hit_x/_y   out  origin of the first positive window
//   first_hit_valid  out  at least one positive window this scan
//   timeout_err      out  sticky: a window timed out this scan
//   overrun          out  sticky: frame_ready arrived during a scan
// -----------------------------------------------------------------------------
module window_scheduler
  import window_scheduler_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int WIN     = WIN_DEF,
  parameter int STEP    = STEP_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_ready,
  output logic              win_start,
  output logic [ADDR_W-1:0] win_origin,
  output logic [7:0]        win_x,
  output logic [6:0]        win_y,
  input  logic              win_done,
  input  logic              win_hit,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [7:0]        hit_count,
  output logic [7:0]        first_hit_x,
  output logic [6:0]        first_hit_y,
  output logic              first_hit_valid,
  output logic              timeout_err,
  output logic              overrun
);

  // ---------------------------------------------------------------------------
  // Grid constants, sized to the registers they are compared/added with.
  // ---------------------------------------------------------------------------
  localparam logic [7:0]        LAST_X      = 8'(calc_last_pos(IMG_W, WIN));
  localparam logic [6:0]        LAST_Y      = 7'(calc_last_pos(IMG_H, WIN));
  localparam logic [7:0]        STEP_X      = 8'(STEP);
  localparam logic [6:0]        STEP_Y      = 7'(STEP);
  localparam logic [ADDR_W-1:0] ORIGIN_STEP = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(calc_row_stride(STEP, IMG_W));
  localparam int                TO_W        = $clog2(TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [7:0]        r_x;
  logic [6:0]        r_y;
  logic [ADDR_W-1:0] r_origin;
  logic [ADDR_W-1:0] r_row_base;   // origin of the first window of this row
  logic [7:0]        r_hit_count;
  logic [7:0]        r_first_x;
  logic [6:0]        r_first_y;
  logic              r_first_valid;
  logic              r_timeout_err;
  logic              r_overrun;

  // ---------------------------------------------------------------------------
  // Decodes
  // ---------------------------------------------------------------------------
  logic              w_issue;
  logic              w_wait;
  logic              w_expired;
  logic              w_row_end;
  logic              w_last_win;
  logic [ADDR_W-1:0] w_next_row;

  assign w_issue    = (r_state == S_ISSUE);
  assign w_wait     = (r_state == S_WAIT);
  assign w_row_end  = (r_x == LAST_X);
  assign w_last_win = w_row_end && (r_y == LAST_Y);
  assign w_next_row = r_row_base + ROW_STRIDE;

  // The counter is loaded in ISSUE so the first WAIT cycle sees TIMEOUT;
  // it then counts one per WAIT cycle and expires on reaching zero.
  window_timeout_counter #(
    .WIDTH    (TO_W),
    .LOAD_VAL (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_issue),
    .i_dec     (w_wait),
    .o_expired (w_expired)
  );

  // ---------------------------------------------------------------------------
  // Scan FSM and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_origin      <= '0;
      r_row_base    <= '0;
      r_hit_count   <= '0;
      r_first_x     <= '0;
      r_first_y     <= '0;
      r_first_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_ready) begin
            r_x           <= '0;
            r_y           <= '0;
            r_origin      <= '0;
            r_row_base    <= '0;
            r_hit_count   <= '0;
            r_first_x     <= '0;
            r_first_y     <= '0;
            r_first_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
            r_state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          // A done arriving in the expiry cycle wins over the timeout.
          if (win_done) begin
            if (win_hit) begin
              r_hit_count <= sat_inc8(r_hit_count);
              if (!r_first_valid) begin
                r_first_x     <= r_x;
                r_first_y     <= r_y;
                r_first_valid <= 1'b1;
              end
            end
            r_state <= S_ADVANCE;
          end else if (w_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          if (w_last_win) begin
            r_state <= S_DONE;
          end else begin
            if (w_row_end) begin
              r_x        <= '0;
              r_y        <= r_y + STEP_Y;
              r_origin   <= w_next_row;
              r_row_base <= w_next_row;
            end else begin
              r_x      <= r_x + STEP_X;
              r_origin <= r_origin + ORIGIN_STEP;
            end
            r_state <= S_ISSUE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // A new frame while a scan is running is dropped and only flagged.
      if (frame_ready && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight decodes of registered state, no combinational inputs.
  // ---------------------------------------------------------------------------
  assign win_start       = w_issue;
  assign win_origin      = r_origin;
  assign win_x           = r_x;
  assign win_y           = r_y;
  assign scan_busy       = (r_state != S_IDLE);
  assign scan_done       = (r_state == S_DONE);
  assign hit_count       = r_hit_count;
  assign first_hit_x     = r_first_x;
  assign first_hit_y     = r_first_y;
  assign first_hit_valid = r_first_valid;
  assign timeout_err     = r_timeout_err;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_window_scheduler.sv
`timescale 1ns/1ps
module tb_window_scheduler;

  localparam int IMG_W   = 160;
  localparam int IMG_H   = 120;
  localparam int WIN     = 24;
  localparam int STEP    = 4;
  localparam int ADDR_W  = 15;
  localparam int TIMEOUT = 4095;
  localparam int NX      = (IMG_W - WIN) / STEP + 1;
  localparam int NY      = (IMG_H - WIN) / STEP + 1;
  localparam int NWIN    = NX * NY;
  localparam int BUDGET  = NWIN * 16 + 4200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_ready = 1'b0;
  logic              win_done;
  logic              win_hit;
  logic              win_start;
  logic [ADDR_W-1:0] win_origin;
  logic [7:0]        win_x;
  logic [6:0]        win_y;
  logic              scan_busy;
  logic              scan_done;
  logic [7:0]        hit_count;
  logic [7:0]        first_hit_x;
  logic [6:0]        first_hit_y;
  logic              first_hit_valid;
  logic              timeout_err;
  logic              overrun;

  window_scheduler #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STEP(STEP),
    .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready),
    .win_start(win_start), .win_origin(win_origin), .win_x(win_x), .win_y(win_y),
    .win_done(win_done), .win_hit(win_hit),
    .scan_busy(scan_busy), .scan_done(scan_done), .hit_count(hit_count),
    .first_hit_x(first_hit_x), .first_hit_y(first_hit_y),
    .first_hit_valid(first_hit_valid), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic flag_error(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Per-window classifier behaviour for the current scan:
  // lat[k] = cycles from win_start to win_done (0 = never answer),
  // hitv[k] = verdict returned with win_done.
  int lat  [NWIN];
  bit hitv [NWIN];

  typedef struct { int x; int y; int origin; } win_t;
  typedef struct { int hits; int fx; int fy; int fvalid; int terr; int ovr; } scan_t;
  win_t  exp_win[$];
  scan_t exp_scan[$];

  int done_seen = 0;

  // ---------------------------------------------------------------------------
  // Classifier model: answers each win_start after lat[k] cycles.
  // Also remembers the buffer address shown when the first hit is returned.
  // ---------------------------------------------------------------------------
  bit rsp_pending = 0;
  int rsp_cnt = 0;
  int rsp_k = 0;
  int first_hit_origin = -1;

  always @(negedge clk) begin
    win_done = 1'b0;
    win_hit  = 1'b0;
    if (!rst_n) begin
      rsp_pending = 0;
    end else begin
      if (rsp_pending) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_pending = 0;
          win_done = 1'b1;
          win_hit  = hitv[rsp_k];
          if (hitv[rsp_k] && first_hit_origin < 0) first_hit_origin = int'(win_origin);
        end
      end
      if (win_start === 1'b1) begin
        if (win_x == 0 && win_y == 0) first_hit_origin = -1;
        rsp_k = (int'(win_y) / STEP) * NX + int'(win_x) / STEP;
        if (rsp_k >= NWIN) rsp_k = NWIN - 1;
        rsp_cnt = lat[rsp_k];
        rsp_pending = (lat[rsp_k] != 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops expectations whenever the DUT presents a window or a result.
  // ---------------------------------------------------------------------------
  win_t  mon_w;
  scan_t mon_s;

  always @(negedge clk) begin
    if (rst_n) begin
      if (win_start === 1'b1) begin
        if (exp_win.size() == 0) begin
          flag_error("unexpected_win_start");
        end else begin
          mon_w = exp_win.pop_front();
          check("win_x", win_x, mon_w.x);
          check("win_y", win_y, mon_w.y);
          check("win_origin", win_origin, mon_w.origin);
        end
      end
      if (scan_done === 1'b1) begin
        done_seen++;
        if (exp_scan.size() == 0) begin
          flag_error("unexpected_scan_done");
        end else begin
          mon_s = exp_scan.pop_front();
          check("windows_left_at_done", exp_win.size(), 0);
          check("hit_count", hit_count, mon_s.hits);
          check("first_hit_valid", first_hit_valid, mon_s.fvalid);
          check("first_hit_x", first_hit_x, mon_s.fx);
          check("first_hit_y", first_hit_y, mon_s.fy);
          check("timeout_err", timeout_err, mon_s.terr);
          check("overrun", overrun, mon_s.ovr);
          check("busy_at_done", scan_busy, 1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // mode 0: no hits; 1: hits at (40,24),(100,96); 2: all hit; 3: random
  task automatic set_policy(input int mode);
    for (int k = 0; k < NWIN; k++) begin
      int x, y;
      x = (k % NX) * STEP;
      y = (k / NX) * STEP;
      lat[k]  = 10;
      hitv[k] = 1'b0;
      case (mode)
        1: hitv[k] = ((x == 40 && y == 24) || (x == 100 && y == 96));
        2: hitv[k] = 1'b1;
        3: begin
          lat[k]  = $urandom_range(12, 1);
          hitv[k] = ($urandom_range(7, 0) == 0);
        end
        default: ;
      endcase
    end
  endtask

  // Builds the expected window sequence and scan result from the grid rules,
  // then pulses frame_ready.
  task automatic start_scan(input bit exp_ovr);
    scan_t s;
    s = '{0, 0, 0, 0, 0, 0};
    for (int k = 0; k < NWIN; k++) begin
      int x, y;
      x = (k % NX) * STEP;
      y = (k / NX) * STEP;
      exp_win.push_back('{x, y, y * IMG_W + x});
      if (lat[k] == 0 || lat[k] > TIMEOUT + 1) begin
        s.terr = 1;
      end else if (hitv[k]) begin
        if (s.fvalid == 0) begin
          s.fvalid = 1;
          s.fx = x;
          s.fy = y;
        end
        s.hits++;
      end
    end
    if (s.hits > 255) s.hits = 255;
    s.ovr = exp_ovr;
    exp_scan.push_back(s);
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("start_latency_win_start", win_start, 1);
    check("start_busy", scan_busy, 1);
  endtask

  task automatic wait_scan(input int budget);
    int n0;
    n0 = done_seen;
    for (int i = 0; i < budget && done_seen == n0; i++) @(negedge clk);
    if (done_seen == n0) begin
      flag_error("scan_done_never_arrived");
      exp_win.delete();
      exp_scan.delete();
    end
    @(negedge clk);
    check("busy_after_done", scan_busy, 0);
    check("done_is_pulse", scan_done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win_start"}, win_start, 0);
    check({tag, "_win_origin"}, win_origin, 0);
    check({tag, "_win_xy"}, {win_x, 1'b0, win_y}, 0);
    check({tag, "_scan_busy"}, scan_busy, 0);
    check({tag, "_scan_done"}, scan_done, 0);
    check({tag, "_hit_count"}, hit_count, 0);
    check({tag, "_first_hit"}, {first_hit_x, 1'b0, first_hit_y, 7'b0, first_hit_valid}, 0);
    check({tag, "_flags"}, {timeout_err, overrun}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    set_policy(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset");

    // Scan 1: no hits.
    set_policy(0);
    start_scan(1'b0);
    wait_scan(BUDGET);

    // Scan 2: two hits; window 7 answers exactly in the expiry cycle.
    set_policy(1);
    lat[7] = TIMEOUT + 1;
    start_scan(1'b0);
    wait_scan(BUDGET);
    check("first_hit_origin", first_hit_origin, 3880);
    repeat (5) @(negedge clk);
    check("results_held", hit_count, 2);

    // Scan 3: window 5 never answered.
    set_policy(0);
    lat[5] = 0;
    hitv[5] = 1'b1;
    start_scan(1'b0);
    wait_scan(BUDGET);

    // Scan 4: every window hits; extra frame_ready mid-scan.
    set_policy(2);
    start_scan(1'b1);
    repeat (500) @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("overrun_set", overrun, 1);
    check("overrun_no_restart_busy", scan_busy, 1);
    wait_scan(BUDGET);

    // Scan 5: reset in the middle, then a clean random scan.
    set_policy(3);
    start_scan(1'b0);
    repeat (3000) @(negedge clk);
    rst_n = 1'b0;
    exp_win.delete();
    exp_scan.delete();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_reset_outputs("after_mid_reset");
    set_policy(3);
    start_scan(1'b0);
    wait_scan(BUDGET);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_scheduler.md
# window_scheduler

Sequences the cascade classifier over every sliding-window position of the 160x120 integral image held in the integral image buffer. Started once per captured frame, it issues one window origin at a time to the classifier with a start/done handshake, counts positive windows, latches the first hit position and reports scan completion. It sits between the detection state machine, which signals that a frame is ready, and the cascade, which evaluates one window per request.

## Interface
Parameters:
- IMG_W, 160, integral image width in pixels
- IMG_H, 120, integral image height in pixels
- WIN, 24, square window side in pixels
- STEP, 4, window stride in x and y
- ADDR_W, 15, buffer address width
- TIMEOUT, 4095, max cycles to wait for win_done

Ports:
- clk  in  1  pixel clock domain (ov7670_pclk); single clock
- rst_n  in  1  asynchronous, active-low reset
- frame_ready  in  1  one-cycle pulse: integral image complete and stable
- win_start  out  1  one-cycle pulse: classifier evaluates window at win_origin
- win_origin  out  ADDR_W  top-left buffer address, y*IMG_W+x
- win_x  out  8  window x origin
- win_y  out  7  window y origin
- win_done  in  1  one-cycle pulse: classifier finished current window
- win_hit  in  1  classifier verdict, qualified by win_done
- scan_busy  out  1  high from scan start until scan_done
- scan_done  out  1  one-cycle pulse at end of scan
- hit_count  out  8  positive windows this scan, saturating
- first_hit_x  out  8  x of first positive window
- first_hit_y  out  7  y of first positive window
- first_hit_valid  out  1  a hit occurred this scan
- timeout_err  out  1  sticky: a window timed out this scan
- overrun  out  1  sticky: frame_ready arrived while busy

## Operation
- Grid: x = 0, STEP, ... , IMG_W-WIN; y = 0, STEP, ... , IMG_H-WIN. Defaults give 35x25 = 875 windows, raster order, x fastest.
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE.
- IDLE: on frame_ready, clear hit_count, first_hit_*, timeout_err, overrun; x=y=0, origin=0; go ISSUE.
- ISSUE: assert win_start one cycle; load timeout counter with TIMEOUT; go WAIT.
- WAIT: on win_done, if win_hit increment hit_count (saturate at 255) and, if first_hit_valid=0, latch first_hit_x/y and set first_hit_valid; go ADVANCE. If counter reaches 0 without win_done: set timeout_err, treat as miss, go ADVANCE. win_done in the expiry cycle counts as done.
- ADVANCE: if last window (x=IMG_W-WIN and y=IMG_H-WIN) go DONE; else if x=IMG_W-WIN then x=0, y+=STEP, origin=row_base+STEP*IMG_W, row_base=origin; else x+=STEP, origin+=STEP; go ISSUE.
- DONE: pulse scan_done, drop scan_busy; go IDLE.
- Origin arithmetic is incremental (adders only, no multiplier); STEP*IMG_W is a compile-time constant.
- frame_ready outside IDLE: ignored, sets overrun. win_done outside WAIT: ignored.
- Reset mid-scan: all state returns to reset values immediately; no scan_done issued.

## Timing
- Reset values: all outputs 0; state IDLE.
- frame_ready at cycle n -> win_start at n+1 (ISSUE registered output), origin 0.
- win_origin, win_x, win_y stable from win_start until the cycle after win_done.
- win_done at cycle m -> next win_start at m+2; per-window overhead 3 cycles plus classifier latency.
- hit_count/first_hit_* update in the cycle after win_done; final values valid when scan_done pulses and held until next frame_ready.
- scan_busy high from the cycle after frame_ready through the DONE cycle.

## Structure
- Shared package: grid constants (IMG_W, IMG_H, WIN, STEP, derived row stride STEP*IMG_W, last x/y) and state encoding enum.
- One natural sub-module: window_timeout_counter (load, decrement, expired flag), reused by other handshaking blocks.

## Test plan
- Reset then frame_ready, classifier model answers win_done 10 cycles after each win_start, win_hit=0 -> exactly 875 win_start pulses, scan_done once, hit_count=0, first_hit_valid=0.
- Same, win_hit=1 only at (x=40,y=24) and (x=100,y=96) -> hit_count=2, first_hit=(40,24), win_origin at first hit = 3880.
- Check origins at row wrap: after (x=136,y=0) next is (0,4) origin 640; last window (136,96) origin 15496.
- Withhold win_done on window 5 -> timeout_err after 4095 cycles, scan continues, 875 windows total; win_done arriving exactly at expiry -> no timeout_err.
- frame_ready pulsed mid-scan -> overrun=1, no restart; all windows hit -> hit_count saturates at 255.
- Assert rst_n low mid-scan, release, frame_ready -> clean restart from origin 0, no stale scan_done.
